// File: rtl/load_strobe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_strobe_pkg
// Description : Shared constants for the load-strobe generator: FSM state
//               encoding and the default data width of the load interface.
// Revision    : 1.0 - initial release
// ============================================================================
package load_strobe_pkg;

    // Default width of the switch nibble and of the loaded data.
    localparam int C_DATA_W_DEFAULT = 4;

    // FSM state encoding, 3-bit, kept fixed for compatibility with
    // existing debug tooling that decodes the state register.
    localparam int         C_STATE_W       = 3;
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_press_db   = 3'd1;
    localparam logic [2:0] c_st_fire       = 3'd2;
    localparam logic [2:0] c_st_held       = 3'd3;
    localparam logic [2:0] c_st_release_db = 3'd4;

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchronizer for an asynchronous board input.
//               Both flops reset to 1, the released level of an active-low
//               pushbutton, so no spurious press is seen out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_sync1;
    logic r_sync2;

    // Two-stage metastability filter; reset (active-low) parks both at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    assign o_sync = r_sync2;

endmodule
`default_nettype wire

// File: rtl/load_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : load_strobe_gen
// Description : Debounces an active-low pushbutton and emits one single-cycle
//               load strobe per press, together with the switch nibble
//               captured on the strobe's FSM entry edge.
//               Optional macro AUTO_REPEAT_EN: while the button stays held,
//               re-fire every REPEAT_CYCLES+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module load_strobe_gen
    import load_strobe_pkg::*;
#(
    parameter int DATA_W          = C_DATA_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    input  logic [DATA_W-1:0] sw,
    output logic              load,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam int                  c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES);

    logic                 w_btn_sync;
    logic                 w_pressed;
    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_cnt_hit;
    logic                 w_rpt_hit;
    logic                 r_load;
    logic [DATA_W-1:0]    r_data;

    btn_sync u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (btn_n),
        .o_sync  (w_btn_sync)
    );

    assign w_pressed = ~w_btn_sync;
    assign w_cnt_hit = (r_cnt == c_cnt_last);

`ifdef AUTO_REPEAT_EN
    localparam int                 c_rpt_w    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rpt_w-1:0] c_rpt_last = c_rpt_w'(REPEAT_CYCLES - 1);
    localparam logic [c_rpt_w-1:0] c_rpt_max  = c_rpt_w'(REPEAT_CYCLES);

    logic [c_rpt_w-1:0] r_rpt_cnt;

    // Repeat counter runs only while staying in HELD; any HELD entry restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rpt_cnt <= '0;
        end else if (r_state == c_st_held && w_next_state == c_st_held) begin
            if (r_rpt_cnt != c_rpt_max) begin
                r_rpt_cnt <= r_rpt_cnt + c_rpt_w'(1);
            end
        end else begin
            r_rpt_cnt <= '0;
        end
    end

    assign w_rpt_hit = (r_rpt_cnt == c_rpt_last);
`else
    logic w_unused_repeat_cfg;

    assign w_rpt_hit           = 1'b0;
    assign w_unused_repeat_cfg = ^(32'(REPEAT_CYCLES));
`endif

    // Next-state decode; every decision looks only at the synchronized level.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_pressed) w_next_state = c_st_press_db;
            end
            c_st_press_db: begin
                if (!w_pressed)     w_next_state = c_st_idle;
                else if (w_cnt_hit) w_next_state = c_st_fire;
            end
            c_st_fire: begin
                w_next_state = c_st_held;
            end
            c_st_held: begin
                if (!w_pressed)     w_next_state = c_st_release_db;
                else if (w_rpt_hit) w_next_state = c_st_fire;
            end
            c_st_release_db: begin
                if (w_pressed)      w_next_state = c_st_held;
                else if (w_cnt_hit) w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_st_idle;
        else      r_state <= w_next_state;
    end

    // Debounce counter: cleared on each state change, saturating otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Strobe is registered from the next-state so it is high exactly while in FIRE.
    always_ff @(posedge clk) begin
        if (!rst) r_load <= 1'b0;
        else      r_load <= (w_next_state == c_st_fire);
    end

    // Switch nibble is captured only on the edge that enters FIRE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
        end else if (w_next_state == c_st_fire) begin
            r_data <= sw;
        end
    end

    assign load     = r_load;
    assign data_out = r_data;
    assign busy     = (r_state != c_st_idle);

endmodule
`default_nettype wire
